// File: rtl/dma_write_controller.sv
// AXI4 write DMA: drains a word stream into memory as INCR bursts.
// One burst in flight; bursts are split at MAX_BURST and 4 KB pages.
module dma_write_controller #(
   parameter int C_M_AXI_ADDR_WIDTH = 32,
   parameter int C_M_AXI_DATA_WIDTH = 32,
   parameter int MAX_BURST          = 16
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              start,
   input  logic [C_M_AXI_ADDR_WIDTH-1:0]     base_addr,
   input  logic [31:0]                       transfer_length,
   output logic                              busy,
   output logic                              done,
   output logic                              error,
   input  logic [C_M_AXI_DATA_WIDTH-1:0]     s_data,
   input  logic                              s_valid,
   output logic                              s_ready,
   output logic [C_M_AXI_ADDR_WIDTH-1:0]     m_axi_awaddr,
   output logic [7:0]                        m_axi_awlen,
   output logic [2:0]                        m_axi_awsize,
   output logic [1:0]                        m_axi_awburst,
   output logic                              m_axi_awvalid,
   input  logic                              m_axi_awready,
   output logic [C_M_AXI_DATA_WIDTH-1:0]     m_axi_wdata,
   output logic [C_M_AXI_DATA_WIDTH/8-1:0]   m_axi_wstrb,
   output logic                              m_axi_wlast,
   output logic                              m_axi_wvalid,
   input  logic                              m_axi_wready,
   input  logic [1:0]                        m_axi_bresp,
   input  logic                              m_axi_bvalid,
   output logic                              m_axi_bready
);

   localparam int AW = C_M_AXI_ADDR_WIDTH;
   localparam int DW = C_M_AXI_DATA_WIDTH;

   typedef enum logic [2:0] {
      S_IDLE, S_ADDR, S_DATA, S_RESP, S_DONE
   } state_t;

   state_t            r_state;
   state_t            w_next;
   logic [AW-1:0]     r_cur_addr;
   logic [31:0]       r_remaining;
   logic [8:0]        r_burst_beats;
   logic [8:0]        r_beat_cnt;
   logic [7:0]        r_awlen;
   logic              r_error;

   logic [AW-1:0]     w_nxt_addr;
   logic [31:0]       w_nxt_rem;
   logic [10:0]       w_4k_beats;
   logic [8:0]        w_nxt_beats;
   logic              w_w_hs;
   logic              w_b_hs;

   assign m_axi_awsize  = 3'b010;
   assign m_axi_awburst = 2'b01;
   assign m_axi_wstrb   = '1;
   assign m_axi_wdata   = s_data;
   assign m_axi_awaddr  = r_cur_addr;
   assign m_axi_awlen   = r_awlen;
   assign error         = r_error;
   assign busy          = (r_state != S_IDLE);
   assign w_w_hs        = m_axi_wvalid & m_axi_wready;
   assign w_b_hs        = m_axi_bvalid & m_axi_bready;

   // address/length of the next burst and its size (page, cap, remaining)
   always_comb begin
      if (r_state == S_IDLE) begin
         w_nxt_addr = base_addr;
         w_nxt_rem  = transfer_length;
      end else begin
         w_nxt_addr = r_cur_addr + AW'({r_burst_beats, 2'b00});
         w_nxt_rem  = r_remaining - 32'(r_burst_beats);
      end
      w_4k_beats  = 11'd1024 - {1'b0, w_nxt_addr[11:2]};
      w_nxt_beats = 9'(MAX_BURST);
      if ({2'b00, w_nxt_beats} > w_4k_beats)
         w_nxt_beats = w_4k_beats[8:0];
      if (w_nxt_rem < 32'(w_nxt_beats))
         w_nxt_beats = w_nxt_rem[8:0];
   end

   // state register
   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   // next-state and channel control decode
   always_comb begin
      w_next        = r_state;
      m_axi_awvalid = 1'b0;
      m_axi_wvalid  = 1'b0;
      m_axi_wlast   = 1'b0;
      m_axi_bready  = 1'b0;
      s_ready       = 1'b0;
      done          = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (start)
               w_next = (transfer_length != 32'd0) ? S_ADDR : S_DONE;
         end
         S_ADDR: begin
            m_axi_awvalid = 1'b1;
            if (m_axi_awready) w_next = S_DATA;
         end
         S_DATA: begin
            m_axi_wvalid = s_valid;
            s_ready      = m_axi_wready;
            m_axi_wlast  = (r_beat_cnt == r_burst_beats - 9'd1);
            if (s_valid && m_axi_wready && m_axi_wlast)
               w_next = S_RESP;
         end
         S_RESP: begin
            m_axi_bready = 1'b1;
            if (m_axi_bvalid)
               w_next = (w_nxt_rem == 32'd0) ? S_DONE : S_ADDR;
         end
         S_DONE: begin
            done   = 1'b1;
            w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // transfer bookkeeping: address, remaining words, burst size, status
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cur_addr    <= '0;
         r_remaining   <= '0;
         r_burst_beats <= '0;
         r_beat_cnt    <= '0;
         r_awlen       <= '0;
         r_error       <= 1'b0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_error <= 1'b0;
                  if (transfer_length != 32'd0) begin
                     r_cur_addr    <= w_nxt_addr;
                     r_remaining   <= w_nxt_rem;
                     r_burst_beats <= w_nxt_beats;
                     r_awlen       <= 8'(w_nxt_beats - 9'd1);
                  end
               end
            end
            S_ADDR: begin
               if (m_axi_awready) r_beat_cnt <= '0;
            end
            S_DATA: begin
               if (w_w_hs) r_beat_cnt <= r_beat_cnt + 9'd1;
            end
            S_RESP: begin
               if (w_b_hs) begin
                  if (m_axi_bresp != 2'b00) r_error <= 1'b1;
                  r_cur_addr  <= w_nxt_addr;
                  r_remaining <= w_nxt_rem;
                  if (w_nxt_rem != 32'd0) begin
                     r_burst_beats <= w_nxt_beats;
                     r_awlen       <= 8'(w_nxt_beats - 9'd1);
                  end
               end
            end
            default: ;
         endcase
      end
   end

   logic [DW-1:0] w_unused_dw;
   assign w_unused_dw = '0;

endmodule

// File: tb/tb_dma_write_controller.sv
// Bench for dma_write_controller: AXI slave model with scoreboards
// for expected AW bursts and W data, optional random backpressure.
module tb_dma_write_controller;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [31:0] base_addr = '0;
   logic [31:0] transfer_length = '0;
   logic        busy, done, error;
   logic [31:0] s_data = '0;
   logic        s_valid = 1'b0;
   logic        s_ready;
   logic [31:0] awaddr;
   logic [7:0]  awlen;
   logic [2:0]  awsize;
   logic [1:0]  awburst;
   logic        awvalid;
   logic        awready = 1'b0;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wlast, wvalid;
   logic        wready = 1'b0;
   logic [1:0]  bresp = 2'b00;
   logic        bvalid = 1'b0;
   logic        bready;

   int n_pass = 0;
   int n_total = 0;

   typedef struct {
      logic [31:0] addr;
      logic [7:0]  len;
   } aw_t;

   aw_t         exp_aw[$];
   logic [31:0] exp_w[$];
   logic [31:0] src[$];

   always #5 clk = ~clk;

   dma_write_controller dut (
      .clk(clk), .rst(rst), .start(start),
      .base_addr(base_addr), .transfer_length(transfer_length),
      .busy(busy), .done(done), .error(error),
      .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
      .m_axi_awaddr(awaddr), .m_axi_awlen(awlen),
      .m_axi_awsize(awsize), .m_axi_awburst(awburst),
      .m_axi_awvalid(awvalid), .m_axi_awready(awready),
      .m_axi_wdata(wdata), .m_axi_wstrb(wstrb),
      .m_axi_wlast(wlast), .m_axi_wvalid(wvalid),
      .m_axi_wready(wready), .m_axi_bresp(bresp),
      .m_axi_bvalid(bvalid), .m_axi_bready(bready)
   );

   task automatic push_aw(input logic [31:0] a, input logic [7:0] l);
      aw_t e;
      e.addr = a;
      e.len  = l;
      exp_aw.push_back(e);
   endtask

   task automatic model_bursts(input logic [31:0] base,
                               input logic [31:0] len);
      logic [31:0] a, r, n, pg;
      a = base;
      r = len;
      while (r != 0) begin
         pg = (32'd4096 - (a % 32'd4096)) / 32'd4;
         n = (r < 32'd16) ? r : 32'd16;
         if (pg < n) n = pg;
         push_aw(a, 8'(n - 1));
         a = a + 4 * n;
         r = r - n;
      end
   endtask

   task automatic run_xfer(input logic [31:0] base,
                           input logic [31:0] len,
                           input bit bp, input int err_b,
                           input bit exp_err, input bit poke);
      int done_cnt, done_cyc, last_b, beat, bidx, src_i;
      bit aw_open, b_owed, b_taken, s_taken, aw_stall;
      logic [31:0] held, w, ew;
      logic [7:0] cur_len;
      logic ewl;
      aw_t a;
      src.delete();
      for (int i = 0; i < int'(len); i++) begin
         w = $urandom;
         src.push_back(w);
         exp_w.push_back(w);
      end
      done_cnt = 0; done_cyc = -1; last_b = -1;
      beat = 0; bidx = 0; src_i = 0; cur_len = '0; held = '0;
      aw_open = 0; b_owed = 0; b_taken = 0; s_taken = 0; aw_stall = 0;
      @(negedge clk);
      start = 1'b1;
      base_addr = base;
      transfer_length = len;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(negedge clk);
         start = poke && (cyc == 3);
         if (poke) begin
            base_addr = 32'h0000_5000;
            transfer_length = 32'd5;
         end
         if (s_taken) begin s_valid = 1'b0; s_taken = 0; end
         if (!s_valid && src_i < int'(len)) begin
            s_valid = bp ? ($urandom_range(0, 2) != 0) : 1'b1;
            s_data = src[src_i];
         end
         awready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
         wready  = bp ? 1'($urandom_range(0, 1)) : 1'b1;
         if (b_taken) begin bvalid = 1'b0; b_taken = 0; end
         if (b_owed && !bvalid) begin
            bvalid = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            bresp = (bidx == err_b) ? 2'b10 : 2'b00;
         end
         #1;
         if (cyc == 0) begin
            n_total++;
            if (len != 0 && {busy, awvalid} !== 2'b11) begin
               $display("FAIL start_latency busy/awvalid=%b want 11",
                        {busy, awvalid});
            end else if (len == 0 && {busy, done, awvalid} !== 3'b110) begin
               $display("FAIL zero_len busy/done/awvalid=%b want 110",
                        {busy, done, awvalid});
            end else n_pass++;
         end
         if (awvalid) begin
            if (aw_stall) begin
               n_total++;
               if (awaddr !== held)
                  $display("FAIL aw_stable awaddr=%h want %h", awaddr, held);
               else n_pass++;
            end
            if (awready) begin
               aw_stall = 0;
               n_total++;
               if (exp_aw.size() == 0) begin
                  $display("FAIL aw_extra awaddr=%h want none", awaddr);
               end else begin
                  a = exp_aw.pop_front();
                  if (awaddr !== a.addr || awlen !== a.len)
                     $display("FAIL aw_burst addr/len=%h/%0d want %h/%0d",
                              awaddr, awlen, a.addr, a.len);
                  else n_pass++;
               end
               cur_len = awlen;
               beat = 0;
               aw_open = 1;
            end else begin
               aw_stall = 1;
               held = awaddr;
            end
         end
         if (wvalid) begin
            n_total++;
            if (!aw_open) $display("FAIL w_before_aw wvalid=1 want 0");
            else n_pass++;
         end
         if (wvalid && wready) begin
            s_taken = 1;
            src_i++;
            ewl = (beat == int'(cur_len));
            n_total++;
            if (exp_w.size() == 0) begin
               $display("FAIL w_extra wdata=%h want none", wdata);
            end else begin
               ew = exp_w.pop_front();
               if (wdata !== ew || wlast !== ewl)
                  $display("FAIL w_beat data/last=%h/%b want %h/%b",
                           wdata, wlast, ew, ewl);
               else n_pass++;
            end
            beat++;
            if (ewl) begin aw_open = 0; b_owed = 1; end
         end
         if (bvalid && bready) begin
            b_taken = 1;
            b_owed = 0;
            bidx++;
            last_b = cyc;
         end
         if (done) begin
            done_cnt++;
            if (done_cnt == 1) begin
               done_cyc = cyc;
               n_total++;
               if (error !== exp_err)
                  $display("FAIL error_at_done error=%b want %b",
                           error, exp_err);
               else n_pass++;
            end
         end
         if (done_cyc >= 0 && cyc == done_cyc + 2) break;
      end
      n_total++;
      if (done_cyc < 0) $display("FAIL timeout done=0 want 1");
      else n_pass++;
      n_total++;
      if (done_cnt !== 1) $display("FAIL done_once count=%0d want 1",
                                   done_cnt);
      else n_pass++;
      n_total++;
      if (exp_aw.size() != 0 || exp_w.size() != 0)
         $display("FAIL leftovers aw/w=%0d/%0d want 0/0",
                  exp_aw.size(), exp_w.size());
      else n_pass++;
      n_total++;
      if (busy !== 1'b0) $display("FAIL idle_after busy=%b want 0", busy);
      else n_pass++;
      if (len != 0) begin
         n_total++;
         if (done_cyc != last_b + 1)
            $display("FAIL done_timing cyc=%0d want %0d",
                     done_cyc, last_b + 1);
         else n_pass++;
      end
      exp_aw.delete();
      exp_w.delete();
      start = 1'b0; s_valid = 1'b0; bvalid = 1'b0;
      awready = 1'b0; wready = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      n_total++;
      if ({busy, done, error, awvalid, wvalid, bready, s_ready, wlast}
          !== 8'h00 || awaddr !== 32'h0 || awlen !== 8'h0)
         $display("FAIL reset_outputs ctl=%b addr=%h len=%h want 0",
                  {busy, done, error, awvalid, wvalid, bready, s_ready,
                   wlast}, awaddr, awlen);
      else n_pass++;
      n_total++;
      if (awsize !== 3'b010 || awburst !== 2'b01 || wstrb !== 4'hF)
         $display("FAIL reset_consts size/burst/strb=%b/%b/%h want 010/01/f",
                  awsize, awburst, wstrb);
      else n_pass++;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_single_burst;
      push_aw(32'h1000, 8'd7);
      run_xfer(32'h1000, 32'd8, 0, -1, 0, 0);
   endtask

   task automatic test_multi_burst;
      push_aw(32'h2000, 8'd15);
      push_aw(32'h2040, 8'd15);
      push_aw(32'h2080, 8'd7);
      run_xfer(32'h2000, 32'd40, 0, -1, 0, 0);
   endtask

   task automatic test_4k_boundary;
      push_aw(32'h0FF8, 8'd1);
      push_aw(32'h1000, 8'd3);
      run_xfer(32'h0FF8, 32'd6, 0, -1, 0, 0);
   endtask

   task automatic test_error_resp;
      push_aw(32'h3000, 8'd15);
      push_aw(32'h3040, 8'd15);
      run_xfer(32'h3000, 32'd32, 0, 1, 1, 0);
   endtask

   task automatic test_zero_len;
      run_xfer(32'h4000, 32'd0, 0, -1, 0, 0);
   endtask

   task automatic test_backpressure;
      model_bursts(32'h0F80, 32'd50);
      run_xfer(32'h0F80, 32'd50, 1, -1, 0, 1);
      model_bursts(32'h6FF0, 32'd21);
      run_xfer(32'h6FF0, 32'd21, 1, 2, 1, 0);
   endtask

   task automatic test_reset_mid;
      bit in_data;
      in_data = 0;
      @(negedge clk);
      start = 1'b1;
      base_addr = 32'h1000;
      transfer_length = 32'd8;
      @(negedge clk);
      start = 1'b0;
      awready = 1'b1;
      s_valid = 1'b1;
      s_data = 32'hA5A5_0001;
      wready = 1'b1;
      for (int i = 0; i < 20 && !in_data; i++) begin
         #1;
         if (wvalid) in_data = 1;
         else @(negedge clk);
      end
      n_total++;
      if (!in_data) $display("FAIL reach_data wvalid=0 want 1");
      else n_pass++;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      #1;
      n_total++;
      if ({busy, done, error, awvalid, wvalid, bready, s_ready, wlast}
          !== 8'h00 || awaddr !== 32'h0 || awlen !== 8'h0)
         $display("FAIL reset_mid ctl=%b addr=%h len=%h want 0",
                  {busy, done, error, awvalid, wvalid, bready, s_ready,
                   wlast}, awaddr, awlen);
      else n_pass++;
      rst = 1'b0;
      s_valid = 1'b0;
      awready = 1'b0;
      wready = 1'b0;
      push_aw(32'h1000, 8'd7);
      run_xfer(32'h1000, 32'd8, 0, -1, 0, 0);
   endtask

   initial begin
      test_reset();
      test_single_burst();
      test_multi_burst();
      test_4k_boundary();
      test_error_resp();
      test_zero_len();
      test_backpressure();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
